// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite responder holding a 2**ADDR_W x DATA_W register file, exported flat on reg_out.
// Optional build macro AXIL_SLV_RO_STATUS_EN turns the top register into a read-only write counter.
module axi4lite_slave_regs #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 2,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic [ADDR_W-1:0]             s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [DATA_W-1:0]             s_axi_wdata,
  input  logic [DATA_W/8-1:0]           s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [ADDR_W-1:0]             s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [DATA_W-1:0]             s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic [(2**ADDR_W)*DATA_W-1:0] reg_out,
  output logic                          wr_pulse
);

  localparam int NREG  = 2**ADDR_W;
  localparam int NSTRB = DATA_W/8;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t           w_state;
  rstate_t           r_state;
  logic              aw_hold;
  logic              w_hold;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [NSTRB-1:0]  w_strb_q;
  logic [DATA_W-1:0] regs [NREG];

  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic              have_aw, have_w, commit, ro_hit, wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NSTRB-1:0]  wr_strb;

  assign aw_hs   = s_axi_awvalid & s_axi_awready;
  assign w_hs    = s_axi_wvalid & s_axi_wready;
  assign b_hs    = s_axi_bvalid & s_axi_bready;
  assign ar_hs   = s_axi_arvalid & s_axi_arready;
  assign r_hs    = s_axi_rvalid & s_axi_rready;
  assign have_aw = aw_hold | aw_hs;
  assign have_w  = w_hold | w_hs;
  assign commit  = (w_state == W_IDLE) & have_aw & have_w;

  // Bypass the hold registers when the handshake lands on the commit edge itself.
  assign wr_addr = aw_hs ? s_axi_awaddr : aw_addr_q;
  assign wr_data = w_hs ? s_axi_wdata : w_data_q;
  assign wr_strb = w_hs ? s_axi_wstrb : w_strb_q;

`ifdef AXIL_SLV_RO_STATUS_EN
  assign ro_hit = (wr_addr == ADDR_W'(NREG-1));
`else
  assign ro_hit = 1'b0;
`endif

  assign wr_en = commit & ~ro_hit & (|wr_strb);

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state       <= W_IDLE;
      aw_hold       <= 1'b0;
      w_hold        <= 1'b0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= 2'b00;
      wr_pulse      <= 1'b0;
    end else begin
      wr_pulse <= wr_en;
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_hold   <= 1'b1;
            aw_addr_q <= s_axi_awaddr;
          end
          if (w_hs) begin
            w_hold   <= 1'b1;
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
          end
          if (commit) begin
            w_state       <= W_RESP;
            s_axi_bvalid  <= 1'b1;
            s_axi_bresp   <= ro_hit ? 2'b10 : 2'b00;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
          end else begin
            s_axi_awready <= ~have_aw;
            s_axi_wready  <= ~have_w;
          end
        end
        W_RESP: begin
          if (b_hs) begin
            w_state       <= W_IDLE;
            s_axi_bvalid  <= 1'b0;
            aw_hold       <= 1'b0;
            w_hold        <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int i = 0; i < NREG; i++) regs[i] <= RESET_VAL;
`ifdef AXIL_SLV_RO_STATUS_EN
      regs[NREG-1] <= '0;
`endif
    end else begin
      for (int i = 0; i < NREG; i++) begin
        for (int b = 0; b < NSTRB; b++) begin
          if (wr_en && (wr_addr == ADDR_W'(i)) && wr_strb[b])
            regs[i][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
`ifdef AXIL_SLV_RO_STATUS_EN
      // Status counter tallies every completed write aimed at the writable registers.
      if (commit && !ro_hit) regs[NREG-1] <= regs[NREG-1] + DATA_W'(1);
`endif
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= 2'b00;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_state       <= R_DATA;
            s_axi_rdata   <= regs[s_axi_araddr];
            s_axi_rresp   <= 2'b00;
            s_axi_rvalid  <= 1'b1;
            s_axi_arready <= 1'b0;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            r_state       <= R_IDLE;
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_reg_out
    assign reg_out[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Scoreboard bench for axi4lite_slave_regs: directed writes/reads, B/R responses checked by a monitor.
// Define AXIL_SLV_RO_STATUS_EN for both RTL and bench to exercise the read-only status register.
module tb_axi4lite_slave_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [7:0]  wdata = '0;
  logic [0:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [1:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [7:0]  rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [31:0] reg_out;
  logic        wr_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] bq [$];
  logic [7:0] rq [$];

  axi4lite_slave_regs dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .reg_out       (reg_out),
    .wr_pulse      (wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the expected response whenever the DUT completes a B or R handshake.
  always @(negedge clk) begin
    if (rst_n && bvalid && bready) begin
      if (bq.size() == 0) chk("b_unexpected", 32'(bvalid), 32'd0);
      else chk("b_resp", 32'(bresp), 32'(bq.pop_front()));
    end
    if (rst_n && rvalid && rready) begin
      if (rq.size() == 0) chk("r_unexpected", 32'(rvalid), 32'd0);
      else begin
        chk("r_resp", 32'(rresp), 32'd0);
        chk("r_data", 32'(rdata), 32'(rq.pop_front()));
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_awready", 32'(awready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_wr_pulse", 32'(wr_pulse), 0);
    chk("rst_reg_out", reg_out, 0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rel_awready_low", 32'(awready), 0);
    tick();
    chk("rel_awready", 32'(awready), 1);
    chk("rel_wready", 32'(wready), 1);
    chk("rel_arready", 32'(arready), 1);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d, input logic s,
                    input logic [1:0] resp, input logic pulse);
    chk("wr_awready", 32'(awready), 1);
    chk("wr_wready", 32'(wready), 1);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    bq.push_back(resp);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_bvalid", 32'(bvalid), 1);
    chk("wr_pulse", 32'(wr_pulse), 32'(pulse));
    tick();
    chk("wr_pulse_clr", 32'(wr_pulse), 0);
    chk("wr_bvalid_clr", 32'(bvalid), 0);
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] e);
    chk("rd_arready", 32'(arready), 1);
    araddr = a; arvalid = 1'b1;
    rq.push_back(e);
    tick();
    arvalid = 1'b0;
    chk("rd_rvalid", 32'(rvalid), 1);
    tick();
    chk("rd_rvalid_clr", 32'(rvalid), 0);
  endtask

  initial begin
    #1;
    do_reset();

    // AW and W together
    wr(2'd1, 8'hA5, 1'b1, 2'b00, 1'b1);
    chk("reg1_a5", 32'(reg_out[15:8]), 32'hA5);
    rd(2'd1, 8'hA5);

    // W first, AW three cycles later, B held with bready low
    bready = 1'b0;
    wdata = 8'h3C; wstrb = 1'b1; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("w_first_wready", 32'(wready), 0);
    chk("w_first_awready", 32'(awready), 1);
    tick();
    chk("w_first_no_b", 32'(bvalid), 0);
    tick();
    chk("w_first_no_commit", 32'(reg_out[23:16]), 0);
    awaddr = 2'd2; awvalid = 1'b1;
    bq.push_back(2'b00);
    tick();
    awvalid = 1'b0;
    chk("late_aw_wr_pulse", 32'(wr_pulse), 1);
    chk("reg2_3c", 32'(reg_out[23:16]), 32'h3C);
    for (int i = 0; i < 4; i++) begin
      chk("b_hold_valid", 32'(bvalid), 1);
      chk("b_hold_resp", 32'(bresp), 0);
      chk("b_hold_awready", 32'(awready), 0);
      tick();
    end
    bready = 1'b1;
    tick();
    chk("b_done_bvalid", 32'(bvalid), 0);
    chk("b_done_awready", 32'(awready), 1);
    chk("b_done_wready", 32'(wready), 1);

    // Read and write of addr 2 on the same edge returns the old value
    awaddr = 2'd2; wdata = 8'h55; wstrb = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 2'd2; arvalid = 1'b1;
    bq.push_back(2'b00);
    rq.push_back(8'h3C);
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("conc_bvalid", 32'(bvalid), 1);
    chk("conc_rvalid", 32'(rvalid), 1);
    tick();
    rd(2'd2, 8'h55);

    // Zero strobe: OKAY, no update, no pulse
    wr(2'd0, 8'hFF, 1'b0, 2'b00, 1'b0);
    chk("strb0_reg0", 32'(reg_out[7:0]), 0);
    rd(2'd0, 8'h00);

    // Reset with a W already held: the held data must be discarded
    wdata = 8'h11; wstrb = 1'b1; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    do_reset();
    chk("rst_clears_regs", reg_out, 0);
    awaddr = 2'd0; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    tick();
    chk("aw_only_no_b", 32'(bvalid), 0);
    chk("aw_only_wready", 32'(wready), 1);
    wdata = 8'h22; wvalid = 1'b1;
    bq.push_back(2'b00);
    tick();
    wvalid = 1'b0;
    chk("aw_first_bvalid", 32'(bvalid), 1);
    chk("aw_first_reg0", 32'(reg_out[7:0]), 32'h22);
    tick();

`ifdef AXIL_SLV_RO_STATUS_EN
    do_reset();
    wr(2'd3, 8'h77, 1'b1, 2'b10, 1'b0);
    chk("ro_reg3_unchanged", 32'(reg_out[31:24]), 0);
    for (int i = 0; i < 257; i++) wr(2'd0, 8'(i + 1), 1'b1, 2'b00, 1'b1);
    rd(2'd3, 8'h01);
    chk("ro_reg3_count", 32'(reg_out[31:24]), 32'h01);
`else
    wr(2'd3, 8'h77, 1'b1, 2'b00, 1'b1);
    rd(2'd3, 8'h77);
    chk("rw_reg3", 32'(reg_out[31:24]), 32'h77);
`endif

    tick();
    chk("b_queue_empty", 32'(bq.size()), 0);
    chk("r_queue_empty", 32'(rq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
